if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_if_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// IfStage (module if_stage)
//
// Instruction-fetch stage.  It keeps a program counter, sends one fetch
// request at a time to the instruction memory, and buffers the returned
// words, each paired with its fall-through address, in a two-entry FIFO.
// The FIFO head is the output seen by decode.
//
// Ports
//   clk          sole clock; all state changes on the rising edge
//   rst          synchronous, active-high reset
//   imem_req     fetch request valid (only in the REQ state)
//   imem_addr    word-aligned fetch address
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  read data valid (only looked at in the WAIT state)
//   imem_rdata   fetched instruction word
//   stall        decode holds; the head entry is not consumed
//   redirect     taken branch / jump resolved downstream (highest priority)
//   redirect_pc  redirect target (low two bits ignored)
//   instr        instruction at the FIFO head (0 when empty)
//   next_pc      fetch address of instr plus 4 (0 when empty)
//   instr_valid  FIFO not empty
//   fetch_cnt    FIFO pops (performance counter)
//   redirect_cnt redirect cycles (performance counter)
//
// Configuration
//   IF_PERF_CNT_EN  when defined, fetch_cnt and redirect_cnt are real 32-bit
//                   wrapping counters; otherwise both are tied to zero and
//                   no counter flops exist.
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] next_pc,
  output logic        instr_valid,
  output logic [31:0] fetch_cnt,
  output logic [31:0] redirect_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Fetch control state
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_next;
  logic        r_kill;

  // Two-entry FIFO of {instr, next_pc}
  logic [31:0] r_fifo_instr [2];
  logic [31:0] r_fifo_npc   [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;

  logic        w_empty;
  logic        w_pop;
  logic        w_rsp;
  logic        w_push;
  logic [1:0]  w_count_next;
  logic [31:0] w_redirect_target;
  logic        w_unused_bits;

  // The target is forced to a word boundary; its low bits are dropped.
  assign w_redirect_target = {redirect_pc[31:2], 2'b00};
  assign w_unused_bits     = &{1'b0, redirect_pc[1:0]};

  assign w_empty = (r_count == 2'd0);
  assign w_pop   = !w_empty && !stall;

  // A response only counts while waiting for one.  It is dropped when the
  // fetch was killed by an earlier redirect or a redirect arrives with it.
  assign w_rsp  = (r_state == S_WAIT) && imem_rvalid;
  assign w_push = w_rsp && !r_kill && !redirect;

  // Occupancy after this cycle's push/pop, ignoring a flush.  The FSM uses
  // it to decide whether there is room for another outstanding fetch.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Memory interface.  A request is only presented in REQ, and never while
  // reset is held so the memory sees nothing until reset is released.
  assign imem_req  = (r_state == S_REQ) && !rst;
  assign imem_addr = r_pc;

  // Decode sees the FIFO head; an empty FIFO presents zeros.
  assign instr_valid = !w_empty;
  assign instr       = w_empty ? 32'd0 : r_fifo_instr[r_rd_ptr];
  assign next_pc     = w_empty ? 32'd0 : r_fifo_npc[r_rd_ptr];

  // FIFO storage and pointers.  A redirect flushes the queue outright,
  // whatever push or pop would otherwise have happened this cycle.
  // Simultaneous push and pop leave the count unchanged; since the write
  // and read pointers are separate, ordering is preserved.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_instr[i] <= 32'd0;
        r_fifo_npc[i]   <= 32'd0;
      end
    end else if (redirect) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_instr[r_wr_ptr] <= imem_rdata;
        r_fifo_npc[r_wr_ptr]   <= r_fetch_next;
        r_wr_ptr               <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_next;
    end
  end

  // Fetch FSM.  Only one request is ever outstanding: REQ issues it, WAIT
  // collects the response, and HOLD parks the fetcher while the FIFO is
  // full.  r_fetch_next remembers the granted address plus 4 so the pushed
  // entry carries the correct fall-through PC even though r_pc has moved on.
  //
  // A redirect always reloads the PC.  If a request is (or is becoming)
  // outstanding with no response yet, the response still has to be
  // absorbed, so the FSM sits in WAIT with r_kill set and throws that
  // word away.  A redirect that coincides with the response simply drops
  // it and goes straight back to REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= {RESET_PC[31:2], 2'b00};
      r_fetch_next <= 32'd0;
      r_kill       <= 1'b0;
    end else if (redirect) begin
      r_pc <= w_redirect_target;
      if (((r_state == S_WAIT) && !imem_rvalid) ||
          ((r_state == S_REQ) && imem_gnt)) begin
        r_state <= S_WAIT;
        r_kill  <= 1'b1;
      end else begin
        r_state <= S_REQ;
        r_kill  <= 1'b0;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          if (imem_gnt) begin
            r_pc         <= r_pc + 32'd4;
            r_fetch_next <= r_pc + 32'd4;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_kill <= 1'b0;
            if (r_kill || (w_count_next < 2'd2)) begin
              r_state <= S_REQ;
            end else begin
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_count_next < 2'd2) begin
            r_state <= S_REQ;
          end
        end
        default: begin
          r_state <= S_REQ;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_redirect_cnt;

  // Performance counters: pops seen by decode and redirect cycles, both
  // free-running and wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt    <= 32'd0;
      r_redirect_cnt <= 32'd0;
    end else begin
      if (w_pop) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (redirect) begin
        r_redirect_cnt <= r_redirect_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt    = r_fetch_cnt;
  assign redirect_cnt = r_redirect_cnt;
`else
  assign fetch_cnt    = 32'd0;
  assign redirect_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// Testbench for if_stage: directed cycle-by-cycle vectors with expected
// values worked out by hand from the fetch-stage behaviour.
// ---------------------------------------------------------------------------
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] next_pc;
  logic        instr_valid;
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;

  int errCount   = 0;
  int checkCount = 0;

`ifdef IF_PERF_CNT_EN
  localparam logic [31:0] EXP_FETCH_CNT    = 32'd5;
  localparam logic [31:0] EXP_REDIRECT_CNT = 32'd2;
`else
  localparam logic [31:0] EXP_FETCH_CNT    = 32'd0;
  localparam logic [31:0] EXP_REDIRECT_CNT = 32'd0;
`endif

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr        (instr),
    .next_pc      (next_pc),
    .instr_valid  (instr_valid),
    .fetch_cnt    (fetch_cnt),
    .redirect_cnt (redirect_cnt)
  );

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive all inputs for the current cycle and let combinational outputs
  // settle before any checks.
  task automatic applyStimulus(input logic g, input logic rv,
                               input logic [31:0] rd, input logic st,
                               input logic rdr, input logic [31:0] rpc);
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
    stall       = st;
    redirect    = rdr;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    nextCycle();
    checkOutput("rst_req_low", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_valid_low", {31'd0, instr_valid}, 32'd0);
    nextCycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    nextCycle();

    // Reset state
    checkOutput("reset_req", {31'd0, imem_req}, 32'd0);
    checkOutput("reset_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("reset_instr", instr, 32'd0);
    checkOutput("reset_next_pc", next_pc, 32'd0);
    checkOutput("reset_fetch_cnt", fetch_cnt, 32'd0);
    checkOutput("reset_redirect_cnt", redirect_cnt, 32'd0);
    nextCycle();
    rst = 1'b0;

    // Back-to-back fetches from the reset PC
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      checkOutput("seq_req", {31'd0, imem_req}, 32'd1);
      checkOutput("seq_addr", imem_addr, 32'h0000_3000 + 32'(4 * k));
      if (k == 0) begin
        checkOutput("seq_first_valid", {31'd0, instr_valid}, 32'd0);
      end else begin
        checkOutput("seq_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("seq_instr", instr, 32'hA000_0000 + 32'(k - 1));
        checkOutput("seq_next_pc", next_pc, 32'h0000_3000 + 32'(4 * k));
      end
      nextCycle();
      applyStimulus(1'b1, 1'b1, 32'hA000_0000 + 32'(k), 1'b0, 1'b0, 32'd0);
      checkOutput("seq_wait_req", {31'd0, imem_req}, 32'd0);
      checkOutput("seq_wait_valid", {31'd0, instr_valid}, 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("seq_last_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("seq_last_instr", instr, 32'hA000_0002);
    checkOutput("seq_last_next_pc", next_pc, 32'h0000_300C);
    checkOutput("seq_last_addr", imem_addr, 32'h0000_300C);
    nextCycle();

    // Stall fills the FIFO, fetcher parks in HOLD, then drains in order
    doReset();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    checkOutput("stall_addr0", imem_addr, 32'h0000_3000);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'hB000_0000, 1'b1, 1'b0, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    checkOutput("stall_addr1", imem_addr, 32'h0000_3004);
    checkOutput("stall_head0", instr, 32'hB000_0000);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'hB000_0001, 1'b1, 1'b0, 32'd0);
    nextCycle();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      checkOutput("hold_req", {31'd0, imem_req}, 32'd0);
      checkOutput("hold_head", instr, 32'hB000_0000);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("drain0_instr", instr, 32'hB000_0000);
    checkOutput("drain0_next_pc", next_pc, 32'h0000_3004);
    nextCycle();
    checkOutput("drain1_instr", instr, 32'hB000_0001);
    checkOutput("drain1_next_pc", next_pc, 32'h0000_3008);
    checkOutput("resume_req", {31'd0, imem_req}, 32'd1);
    checkOutput("resume_addr", imem_addr, 32'h0000_3008);
    nextCycle();
    checkOutput("drained_valid", {31'd0, instr_valid}, 32'd0);

    // Redirect while waiting: the in-flight word must be thrown away
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_4002);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
    checkOutput("kill_wait_req", {31'd0, imem_req}, 32'd0);
    checkOutput("kill_wait_valid", {31'd0, instr_valid}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("kill_drop_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("kill_new_addr", imem_addr, 32'h0000_4000);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'hC000_0000, 1'b0, 1'b0, 32'd0);
    checkOutput("kill_pre_rsp_valid", {31'd0, instr_valid}, 32'd0);
    nextCycle();

    // Redirect together with a response while decode is stalled
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    checkOutput("tgt_instr", instr, 32'hC000_0000);
    checkOutput("tgt_next_pc", next_pc, 32'h0000_4004);
    checkOutput("tgt_next_addr", imem_addr, 32'h0000_4004);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'hC000_0001, 1'b1, 1'b1, 32'hFFFF_FFFC);
    checkOutput("flush_pre_valid", {31'd0, instr_valid}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    checkOutput("flush_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("flush_instr", instr, 32'd0);
    checkOutput("flush_req", {31'd0, imem_req}, 32'd1);
    checkOutput("flush_addr", imem_addr, 32'hFFFF_FFFC);
    nextCycle();

    // PC wrap at the top of the address space
    applyStimulus(1'b0, 1'b1, 32'hC000_0002, 1'b0, 1'b0, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("wrap_instr", instr, 32'hC000_0002);
    checkOutput("wrap_next_pc", next_pc, 32'h0000_0000);
    checkOutput("wrap_addr", imem_addr, 32'h0000_0000);
    nextCycle();

    // Performance counters: five pops then two redirects
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b1, 32'hD000_0000 + 32'(k), 1'b0, 1'b0, 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("cnt_last_instr", instr, 32'hD000_0004);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_5000);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_6000);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("cnt_redirect_addr", imem_addr, 32'h0000_6000);
    checkOutput("cnt_fetch", fetch_cnt, EXP_FETCH_CNT);
    checkOutput("cnt_redirect", redirect_cnt, EXP_REDIRECT_CNT);
    nextCycle();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
